// File: rtl/frame_buf_multi_if.sv
// Purpose: bundles the writer, reader and status signals of frame_buf_multi.
//   The clock and reset are not part of this bundle.
// Ports (signals):
//   wr_en_in      writer -> buf  active-low write request
//   data_in       writer -> buf  write word
//   wr_rdy        buf -> writer  writer may present a word this cycle
//   rd_en_in      reader -> buf  active-low read request
//   rd_rdy        buf -> reader  at least one committed frame is available
//   data_out      buf -> reader  registered read word
//   rd_data_valid buf -> reader  data_out carries a freshly fetched word
//   buf_cnt       status         committed frames that are not yet fully read
//   wr_buf_idx    status         buffer being filled
//   rd_buf_idx    status         buffer being drained
//   drop_cnt      status         frames discarded because the ring was full
// Modports: master = source/sink side, slave = the frame buffer itself.
interface frame_buf_multi_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BUFS   = 2
);
  localparam int CNT_W = $clog2(NUM_BUFS + 1);
  localparam int IDX_W = $clog2(NUM_BUFS);

  logic                  wr_en_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_rdy;
  logic                  rd_en_in;
  logic                  rd_rdy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_data_valid;
  logic [CNT_W-1:0]      buf_cnt;
  logic [IDX_W-1:0]      wr_buf_idx;
  logic [IDX_W-1:0]      rd_buf_idx;
  logic [15:0]           drop_cnt;

  modport master (
    output wr_en_in, data_in, rd_en_in,
    input  wr_rdy, rd_rdy, data_out, rd_data_valid,
           buf_cnt, wr_buf_idx, rd_buf_idx, drop_cnt
  );

  modport slave (
    input  wr_en_in, data_in, rd_en_in,
    output wr_rdy, rd_rdy, data_out, rd_data_valid,
           buf_cnt, wr_buf_idx, rd_buf_idx, drop_cnt
  );
endinterface

// File: rtl/frame_buf_multi.sv
// Purpose: single-clock ring of NUM_BUFS frame buffers, BUF_SIZE words each.
//   The writer fills whole frames; the reader only drains committed frames,
//   oldest first, so a frame is never read while it is being written.
//   WR_MODE=0 stalls the writer when the ring is full, WR_MODE=1 drops the
//   whole incoming frame instead and counts it in drop_cnt.
// Ports:
//   clk    posedge clock for all logic
//   reset  synchronous, active-high
//   bus    frame_buf_multi_if.slave (write/read handshakes and status)
//
// Write FSM
//   state  | meaning
//   W_IDLE | at a frame boundary, offset is 0
//   W_FILL | storing a frame into buffer wr_buf_idx
//   W_DROP | ring was full at frame start, swallowing the frame
// Read FSM
//   state  | meaning
//   R_IDLE | at a frame boundary, next accepted read fetches offset 0
//   R_READ | part way through draining buffer rd_buf_idx
module frame_buf_multi #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_SIZE   = 500,
  parameter int NUM_BUFS   = 2,
  parameter int WR_MODE    = 0
) (
  input logic             clk,
  input logic             reset,
  frame_buf_multi_if.slave bus
);

  localparam int DEPTH      = NUM_BUFS * BUF_SIZE;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_W      = $clog2(NUM_BUFS + 1);
  localparam int IDX_W      = $clog2(NUM_BUFS);
  localparam int OFF_W      = $clog2(BUF_SIZE);

  localparam logic [OFF_W-1:0]      OFF_LAST  = OFF_W'(BUF_SIZE - 1);
  localparam logic [OFF_W-1:0]      OFF_ONE   = OFF_W'(1);
  localparam logic [ADDR_WIDTH-1:0] BASE_STEP = ADDR_WIDTH'(BUF_SIZE);
  localparam logic [ADDR_WIDTH-1:0] BASE_LAST = ADDR_WIDTH'((NUM_BUFS - 1) * BUF_SIZE);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_BUFS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(NUM_BUFS);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_FILL = 2'd1;
  localparam logic [1:0] W_DROP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_READ = 1'b1;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [1:0]            w_state;
  logic [0:0]            r_state;
  logic [OFF_W-1:0]      wr_off;
  logic [OFF_W-1:0]      rd_off;
  logic [ADDR_WIDTH-1:0] wr_base;
  logic [ADDR_WIDTH-1:0] rd_base;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [CNT_W-1:0]      cnt;
  logic [15:0]           drops;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_vld;

  logic full;
  logic wr_rdy_c;
  logic rd_rdy_c;
  logic wr_acc;
  logic rd_acc;
  logic wr_store;
  logic commit;
  logic release_buf;

  always_comb begin
    full     = (cnt == CNT_FULL);
    // In drop mode the writer is never back-pressured; a full ring just
    // sends the next frame to W_DROP.
    wr_rdy_c = (WR_MODE != 0) ? 1'b1 : (!full || (w_state == W_FILL));
    rd_rdy_c = (cnt != '0);
    wr_acc   = !bus.wr_en_in && wr_rdy_c;
    rd_acc   = !bus.rd_en_in && rd_rdy_c;
    wr_store = wr_acc && ((w_state == W_FILL) || ((w_state == W_IDLE) && !full));
    // W_IDLE always sits at offset 0 and BUF_SIZE >= 2, so only W_FILL commits.
    commit      = wr_store && (w_state == W_FILL) && (wr_off == OFF_LAST);
    release_buf = rd_acc && (rd_off == OFF_LAST);
    wr_addr  = wr_base + ADDR_WIDTH'(wr_off);
    rd_addr  = rd_base + ADDR_WIDTH'(rd_off);
  end

  // Write FSM: offset, base, buffer index and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      wr_off  <= '0;
      wr_base <= '0;
      wr_idx  <= '0;
      drops   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_acc) begin
            wr_off  <= OFF_ONE;
            w_state <= full ? W_DROP : W_FILL;
          end
        end
        W_FILL: begin
          if (wr_acc) begin
            if (wr_off == OFF_LAST) begin
              wr_off  <= '0;
              wr_base <= (wr_base == BASE_LAST) ? '0 : wr_base + BASE_STEP;
              wr_idx  <= (wr_idx == IDX_LAST) ? '0 : wr_idx + IDX_ONE;
              w_state <= W_IDLE;
            end else begin
              wr_off <= wr_off + OFF_ONE;
            end
          end
        end
        W_DROP: begin
          if (wr_acc) begin
            if (wr_off == OFF_LAST) begin
              wr_off  <= '0;
              if (drops != 16'hFFFF) drops <= drops + 16'd1;
              w_state <= W_IDLE;
            end else begin
              wr_off <= wr_off + OFF_ONE;
            end
          end
        end
        default: begin
          wr_off  <= '0;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // Storage array, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_store && !reset) mem[wr_addr] <= bus.data_in;
  end

  // Read FSM: fetches with one cycle of latency and releases on the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      rd_off  <= '0;
      rd_base <= '0;
      rd_idx  <= '0;
      rd_word <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld <= rd_acc;
      if (rd_acc) begin
        rd_word <= mem[rd_addr];
        case (r_state)
          R_IDLE, R_READ: begin
            if (rd_off == OFF_LAST) begin
              rd_off  <= '0;
              rd_base <= (rd_base == BASE_LAST) ? '0 : rd_base + BASE_STEP;
              rd_idx  <= (rd_idx == IDX_LAST) ? '0 : rd_idx + IDX_ONE;
              r_state <= R_IDLE;
            end else begin
              rd_off  <= rd_off + OFF_ONE;
              r_state <= R_READ;
            end
          end
          default: r_state <= R_IDLE;
        endcase
      end
    end
  end

  // Committed-frame count; a commit and a release in the same cycle cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({commit && !full, release_buf})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.wr_rdy        = wr_rdy_c;
  assign bus.rd_rdy        = rd_rdy_c;
  assign bus.data_out      = rd_word;
  assign bus.rd_data_valid = rd_vld;
  assign bus.buf_cnt       = cnt;
  assign bus.wr_buf_idx    = wr_idx;
  assign bus.rd_buf_idx    = rd_idx;
  assign bus.drop_cnt      = drops;

endmodule

// File: tb/tb_frame_buf_multi.sv
// Purpose: directed bench for frame_buf_multi with DATA_WIDTH=8, BUF_SIZE=4,
//   NUM_BUFS=2. dut0 runs in stall mode, dut1 in drop mode.
// Ports: none (top-level bench).
module tb_frame_buf_multi;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  frame_buf_multi_if #(.DATA_WIDTH(8), .NUM_BUFS(2)) bus0 ();
  frame_buf_multi_if #(.DATA_WIDTH(8), .NUM_BUFS(2)) bus1 ();

  frame_buf_multi #(.DATA_WIDTH(8), .BUF_SIZE(4), .NUM_BUFS(2), .WR_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  frame_buf_multi #(.DATA_WIDTH(8), .BUF_SIZE(4), .NUM_BUFS(2), .WR_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  typedef struct {
    logic       wn;
    logic [7:0] din;
    logic       rn;
    logic       e_vld;
    logic [7:0] e_dout;
    logic [1:0] e_cnt;
    logic       e_wrdy;
    logic       e_rrdy;
    logic       e_widx;
    logic       e_ridx;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic wn, input logic [7:0] din, input logic rn,
                     input logic vld, input logic [7:0] dout, input logic [1:0] cnt,
                     input logic wrdy, input logic rrdy, input logic widx, input logic ridx);
    vec_t v;
    v.wn = wn; v.din = din; v.rn = rn; v.e_vld = vld; v.e_dout = dout;
    v.e_cnt = cnt; v.e_wrdy = wrdy; v.e_rrdy = rrdy; v.e_widx = widx; v.e_ridx = ridx;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive dut0 inputs for one edge, then sample 1 time unit after it.
  task automatic cyc0(input logic wn, input logic [7:0] din, input logic rn);
    bus0.wr_en_in = wn;
    bus0.data_in  = din;
    bus0.rd_en_in = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input logic wn, input logic [7:0] din, input logic rn);
    bus1.wr_en_in = wn;
    bus1.data_in  = din;
    bus1.rd_en_in = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic rd0(input string name, input logic [7:0] exp);
    cyc0(1'b1, 8'h00, 1'b0);
    chk({name, " vld"}, 32'(bus0.rd_data_valid), 32'd1);
    chk({name, " data"}, 32'(bus0.data_out), 32'(exp));
  endtask

  task automatic rd1(input string name, input logic [7:0] exp);
    cyc1(1'b1, 8'h00, 1'b0);
    chk({name, " vld"}, 32'(bus1.rd_data_valid), 32'd1);
    chk({name, " data"}, 32'(bus1.data_out), 32'(exp));
  endtask

  initial begin
    bus0.wr_en_in = 1'b1; bus0.data_in = '0; bus0.rd_en_in = 1'b1;
    bus1.wr_en_in = 1'b1; bus1.data_in = '0; bus1.rd_en_in = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst cnt", 32'(bus0.buf_cnt), 0);
    chk("rst vld", 32'(bus0.rd_data_valid), 0);
    chk("rst dout", 32'(bus0.data_out), 0);
    chk("rst rrdy", 32'(bus0.rd_rdy), 0);
    chk("rst wrdy", 32'(bus0.wr_rdy), 1);
    chk("rst widx", 32'(bus0.wr_buf_idx), 0);
    chk("rst ridx", 32'(bus0.rd_buf_idx), 0);
    chk("rst drop", 32'(bus1.drop_cnt), 0);

    // Single frame round trip, two frames filling the ring, ignored 9th word,
    // then idle reads against an empty ring.
    //   wn din   rn vld dout cnt wrdy rrdy widx ridx
    add(0, 8'h10, 1, 0, 8'h00, 0, 1, 0, 0, 0);
    add(0, 8'h11, 1, 0, 8'h00, 0, 1, 0, 0, 0);
    add(0, 8'h12, 1, 0, 8'h00, 0, 1, 0, 0, 0);
    add(0, 8'h13, 1, 0, 8'h00, 1, 1, 1, 1, 0);
    add(1, 8'h00, 0, 1, 8'h10, 1, 1, 1, 1, 0);
    add(1, 8'h00, 0, 1, 8'h11, 1, 1, 1, 1, 0);
    add(1, 8'h00, 0, 1, 8'h12, 1, 1, 1, 1, 0);
    add(1, 8'h00, 0, 1, 8'h13, 0, 1, 0, 1, 1);
    add(1, 8'h00, 1, 0, 8'h13, 0, 1, 0, 1, 1);
    add(0, 8'h20, 1, 0, 8'h13, 0, 1, 0, 1, 1);
    add(0, 8'h21, 1, 0, 8'h13, 0, 1, 0, 1, 1);
    add(0, 8'h22, 1, 0, 8'h13, 0, 1, 0, 1, 1);
    add(0, 8'h23, 1, 0, 8'h13, 1, 1, 1, 0, 1);
    add(0, 8'h30, 1, 0, 8'h13, 1, 1, 1, 0, 1);
    add(0, 8'h31, 1, 0, 8'h13, 1, 1, 1, 0, 1);
    add(0, 8'h32, 1, 0, 8'h13, 1, 1, 1, 0, 1);
    add(0, 8'h33, 1, 0, 8'h13, 2, 0, 1, 1, 1);
    add(0, 8'h99, 1, 0, 8'h13, 2, 0, 1, 1, 1);
    add(1, 8'h00, 0, 1, 8'h20, 2, 0, 1, 1, 1);
    add(1, 8'h00, 0, 1, 8'h21, 2, 0, 1, 1, 1);
    add(1, 8'h00, 0, 1, 8'h22, 2, 0, 1, 1, 1);
    add(1, 8'h00, 0, 1, 8'h23, 1, 1, 1, 1, 0);
    add(1, 8'h00, 0, 1, 8'h30, 1, 1, 1, 1, 0);
    add(1, 8'h00, 0, 1, 8'h31, 1, 1, 1, 1, 0);
    add(1, 8'h00, 0, 1, 8'h32, 1, 1, 1, 1, 0);
    add(1, 8'h00, 0, 1, 8'h33, 0, 1, 0, 1, 1);
    for (int k = 0; k < 5; k++) add(1, 8'h00, 0, 0, 8'h33, 0, 1, 0, 1, 1);

    for (int i = 0; i < vq.size(); i++) begin
      cyc0(vq[i].wn, vq[i].din, vq[i].rn);
      chk($sformatf("v%0d vld", i), 32'(bus0.rd_data_valid), 32'(vq[i].e_vld));
      chk($sformatf("v%0d dout", i), 32'(bus0.data_out), 32'(vq[i].e_dout));
      chk($sformatf("v%0d cnt", i), 32'(bus0.buf_cnt), 32'(vq[i].e_cnt));
      chk($sformatf("v%0d wrdy", i), 32'(bus0.wr_rdy), 32'(vq[i].e_wrdy));
      chk($sformatf("v%0d rrdy", i), 32'(bus0.rd_rdy), 32'(vq[i].e_rrdy));
      chk($sformatf("v%0d widx", i), 32'(bus0.wr_buf_idx), 32'(vq[i].e_widx));
      chk($sformatf("v%0d ridx", i), 32'(bus0.rd_buf_idx), 32'(vq[i].e_ridx));
    end
    cyc0(1'b1, 8'h00, 1'b1);
    chk("stall drop", 32'(bus0.drop_cnt), 0);

    // Reset in the middle of a frame, then a clean frame from buffer 0.
    cyc0(1'b0, 8'h40, 1'b1);
    cyc0(1'b0, 8'h41, 1'b1);
    reset = 1'b1;
    cyc0(1'b1, 8'h00, 1'b1);
    reset = 1'b0;
    chk("mid rst cnt", 32'(bus0.buf_cnt), 0);
    chk("mid rst vld", 32'(bus0.rd_data_valid), 0);
    chk("mid rst dout", 32'(bus0.data_out), 0);
    chk("mid rst rrdy", 32'(bus0.rd_rdy), 0);
    chk("mid rst widx", 32'(bus0.wr_buf_idx), 0);
    chk("mid rst ridx", 32'(bus0.rd_buf_idx), 0);
    chk("mid rst drop", 32'(bus0.drop_cnt), 0);
    for (int k = 0; k < 3; k++) cyc0(1'b0, 8'h50 + 8'(k), 1'b1);
    chk("post rst partial cnt", 32'(bus0.buf_cnt), 0);
    cyc0(1'b0, 8'h53, 1'b1);
    chk("post rst cnt", 32'(bus0.buf_cnt), 1);
    chk("post rst ridx", 32'(bus0.rd_buf_idx), 0);
    for (int k = 0; k < 4; k++) rd0($sformatf("post rst rd%0d", k), 8'h50 + 8'(k));
    chk("post rst empty", 32'(bus0.rd_rdy), 0);

    // Final write of one frame and final read of another in the same cycle.
    reset = 1'b1;
    cyc0(1'b1, 8'h00, 1'b1);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) cyc0(1'b0, 8'h60 + 8'(k), 1'b1);
    for (int k = 0; k < 3; k++) cyc0(1'b0, 8'h70 + 8'(k), 1'b1);
    chk("sim pre cnt", 32'(bus0.buf_cnt), 1);
    chk("sim pre widx", 32'(bus0.wr_buf_idx), 1);
    for (int k = 0; k < 3; k++) rd0($sformatf("sim rd%0d", k), 8'h60 + 8'(k));
    chk("sim pre ridx", 32'(bus0.rd_buf_idx), 0);
    cyc0(1'b0, 8'h73, 1'b0);
    chk("sim vld", 32'(bus0.rd_data_valid), 1);
    chk("sim dout", 32'(bus0.data_out), 32'h63);
    chk("sim cnt", 32'(bus0.buf_cnt), 1);
    chk("sim ridx", 32'(bus0.rd_buf_idx), 1);
    chk("sim widx", 32'(bus0.wr_buf_idx), 0);
    for (int k = 0; k < 4; k++) cyc0(1'b0, 8'h80 + 8'(k), 1'b1);
    chk("wrap cnt", 32'(bus0.buf_cnt), 2);
    chk("wrap wrdy", 32'(bus0.wr_rdy), 0);
    chk("wrap widx", 32'(bus0.wr_buf_idx), 1);
    for (int k = 0; k < 4; k++) rd0($sformatf("wrap b1 rd%0d", k), 8'h70 + 8'(k));
    chk("wrap mid cnt", 32'(bus0.buf_cnt), 1);
    chk("wrap mid ridx", 32'(bus0.rd_buf_idx), 0);
    for (int k = 0; k < 4; k++) rd0($sformatf("wrap b0 rd%0d", k), 8'h80 + 8'(k));
    chk("wrap end cnt", 32'(bus0.buf_cnt), 0);

    // Drop mode: third frame arrives with the ring full and is discarded.
    for (int k = 0; k < 4; k++) cyc1(1'b0, 8'hA0 + 8'(k), 1'b1);
    chk("drop A cnt", 32'(bus1.buf_cnt), 1);
    for (int k = 0; k < 4; k++) cyc1(1'b0, 8'hB0 + 8'(k), 1'b1);
    chk("drop B cnt", 32'(bus1.buf_cnt), 2);
    chk("drop full wrdy", 32'(bus1.wr_rdy), 1);
    for (int k = 0; k < 4; k++) begin
      cyc1(1'b0, 8'hC0 + 8'(k), 1'b1);
      chk($sformatf("drop C%0d wrdy", k), 32'(bus1.wr_rdy), 1);
    end
    chk("drop cnt", 32'(bus1.drop_cnt), 1);
    chk("drop buf cnt", 32'(bus1.buf_cnt), 2);
    chk("drop widx", 32'(bus1.wr_buf_idx), 0);
    for (int k = 0; k < 4; k++) rd1($sformatf("drop A rd%0d", k), 8'hA0 + 8'(k));
    for (int k = 0; k < 4; k++) rd1($sformatf("drop B rd%0d", k), 8'hB0 + 8'(k));
    chk("drop end cnt", 32'(bus1.buf_cnt), 0);
    chk("drop end rrdy", 32'(bus1.rd_rdy), 0);
    cyc1(1'b1, 8'h00, 1'b0);
    chk("drop no C vld", 32'(bus1.rd_data_valid), 0);
    cyc1(1'b1, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
